// File: rtl/cochlea_chan_seq.sv
// cochlea_chan_seq: digital sequencer for one I/Q analog cochlea channel core.
// Generates cclk/div2/lo for the core, samples comparator decisions on
// phi1b_dig edges into the fb1 feedback bit, and counts high decisions over a
// programmable window. Each completed window is handed to the host over a
// valid/ready port.
// Optional build macro: COCHLEA_CNT_SAT_EN. When defined, the event counter
// saturates at all-ones and out_sat flags windows where an increment was
// blocked. When undefined, the counter wraps and out_sat is tied 0.
`timescale 1ns/1ps

module cochlea_chan_seq #(
  parameter int DIV_W       = 8,
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic             cfg_lo_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [WIN_W-1:0] cfg_win,
  output logic             cclk,
  output logic             div2,
  output logic             lo,
  output logic             fb1,
  input  logic             high_buf,
  input  logic             phi1b_dig,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_overrun,
  output logic             out_sat
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic               run_active;

  logic [SYNC_STAGES-1:0] hb_sync_p0;
  logic [SYNC_STAGES-1:0] phi_sync_p0;
  logic                   phi_last_p1;
  logic                   hb_s;
  logic                   phi_edge;

  logic [DIV_W-1:0]   phase;
  logic               cclk_rise;

  logic [CNT_W-1:0]   evt_cnt;
  logic [CNT_W-1:0]   evt_inc;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIN_W-1:0]   win_len;
  logic               win_end;

  // Event counter increment; saturating variant blocks at all-ones.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef COCHLEA_CNT_SAT_EN
    cnt_inc = (&v) ? v : v + CNT_W'(1);
`else
    cnt_inc = v + CNT_W'(1);
`endif
  endfunction

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state; the datapath runs only while RUN and en is still high,
  // so dropping en parks everything on the same edge that leaves RUN.
  always_comb begin
    state_nxt  = state;
    run_active = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en) state_nxt = IDLE;
        else     run_active = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bring the asynchronous comparator and phase inputs into wb_clk_i; both
  // chains have equal depth so the sampled decision lines up with its phi edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hb_sync_p0  <= '0;
      phi_sync_p0 <= '0;
      phi_last_p1 <= 1'b0;
    end else begin
      hb_sync_p0  <= {hb_sync_p0[SYNC_STAGES-2:0], high_buf};
      phi_sync_p0 <= {phi_sync_p0[SYNC_STAGES-2:0], phi1b_dig};
      phi_last_p1 <= phi_sync_p0[SYNC_STAGES-1];
    end
  end

  assign hb_s      = hb_sync_p0[SYNC_STAGES-1];
  assign phi_edge  = phi_sync_p0[SYNC_STAGES-1] & ~phi_last_p1;
  assign cclk_rise = run_active && (phase == '0) && !cclk;
  assign evt_inc   = hb_s ? cnt_inc(evt_cnt) : evt_cnt;
  assign win_end   = run_active && phi_edge && (win_cnt == win_len);

  // Clock divider chain: cclk toggles on phase underflow, div2 on cclk rise,
  // lo on div2 rise. Outside RUN the phase is preloaded so the first cclk
  // rise lands cfg_div+1 cycles after entry.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      phase <= '0;
      cclk  <= 1'b0;
      div2  <= 1'b0;
      lo    <= 1'b0;
    end else if (run_active) begin
      if (phase == '0) begin
        phase <= cfg_div;
        cclk  <= ~cclk;
      end else begin
        phase <= phase - DIV_W'(1);
      end
      if (cclk_rise) div2 <= ~div2;
      if (!cfg_lo_en)              lo <= 1'b0;
      else if (cclk_rise && !div2) lo <= ~lo;
    end else begin
      phase <= cfg_div;
      cclk  <= 1'b0;
      div2  <= 1'b0;
      lo    <= 1'b0;
    end
  end

  // Decision sampling, windowed counting and the result handshake. A window
  // end in the same cycle as an accept reloads the result and keeps it valid.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fb1         <= 1'b0;
      evt_cnt     <= '0;
      win_cnt     <= '0;
      win_len     <= '0;
      out_count   <= '0;
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (run_active) begin
        if (phi_edge) begin
          fb1 <= hb_s;
          if (win_end) begin
            out_count <= evt_inc;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) out_overrun <= 1'b1;
            evt_cnt   <= '0;
            win_cnt   <= '0;
            win_len   <= cfg_win;
          end else begin
            evt_cnt   <= evt_inc;
            win_cnt   <= win_cnt + WIN_W'(1);
          end
        end
      end else begin
        fb1     <= 1'b0;
        evt_cnt <= '0;
        win_cnt <= '0;
        win_len <= cfg_win;
      end
    end
  end

`ifdef COCHLEA_CNT_SAT_EN
  logic sat_blk;
  logic inc_blocked;

  assign inc_blocked = run_active && phi_edge && hb_s && (&evt_cnt);

  // Track blocked increments within the window and publish them with the result.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sat_blk <= 1'b0;
      out_sat <= 1'b0;
    end else if (!run_active) begin
      sat_blk <= 1'b0;
    end else if (win_end) begin
      out_sat <= sat_blk | inc_blocked;
      sat_blk <= 1'b0;
    end else if (inc_blocked) begin
      sat_blk <= 1'b1;
    end
  end
`else
  assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_cochlea_chan_seq.sv
// Directed bench for cochlea_chan_seq (CNT_W=4 so the wrap/saturate case is short).
`timescale 1ns/1ps

module tb_cochlea_chan_seq;

  localparam int DIV_W       = 8;
  localparam int WIN_W       = 16;
  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_lo_en;
  logic [DIV_W-1:0] cfg_div;
  logic [WIN_W-1:0] cfg_win;
  logic             cclk, div2, lo, fb1;
  logic             high_buf, phi;
  logic [CNT_W-1:0] out_count;
  logic             out_valid, out_ready, out_overrun, out_sat;

  int n_checks = 0;
  int n_errors = 0;

  cochlea_chan_seq #(
    .DIV_W(DIV_W), .WIN_W(WIN_W), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .cfg_lo_en(cfg_lo_en),
    .cfg_div(cfg_div), .cfg_win(cfg_win), .cclk(cclk), .div2(div2), .lo(lo),
    .fb1(fb1), .high_buf(high_buf), .phi1b_dig(phi), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_overrun(out_overrun),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One phi1b_dig pulse carrying decision hb; rdy is raised only for the
  // cycle in which the synced edge is acted upon.
  task automatic pulse(input logic hb, input logic rdy);
    high_buf = hb;
    phi = 1'b1;
    tick;
    tick;
    out_ready = rdy;
    tick;
    out_ready = 1'b0;
    phi = 1'b0;
    tick;
    tick;
  endtask

  task automatic pulses(input int n, input logic hb);
    for (int i = 0; i < n; i++) pulse(hb, 1'b0);
  endtask

  task automatic restart(input logic [WIN_W-1:0] win);
    en = 1'b0;
    tick;
    tick;
    cfg_win = win;
    en = 1'b1;
    tick;
    tick;
  endtask

  task automatic accept;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic wait_cclk_high(input string tag);
    int k;
    k = 0;
    while (!cclk && k < 20) begin
      tick;
      k++;
    end
    check(tag, cclk, 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_r[$], d_r[$], l_r[$];
    logic pc, pd, pl;
    int nc, nl;

    rst = 1'b1; en = 1'b0; cfg_lo_en = 1'b1; cfg_div = 8'd3; cfg_win = 16'd9;
    high_buf = 1'b0; phi = 1'b0; out_ready = 1'b0;
    tick; tick; tick;
    check("rst_cclk", cclk, 0);
    check("rst_div2", div2, 0);
    check("rst_lo", lo, 0);
    check("rst_fb1", fb1, 0);
    check("rst_count", out_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overrun", out_overrun, 0);
    check("rst_sat", out_sat, 0);
    rst = 1'b0;
    tick;

    // clock generation, cfg_div=3 with LO enabled
    en = 1'b1;
    pc = 1'b0; pd = 1'b0; pl = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tick;
      if (cclk && !pc) c_r.push_back(t);
      if (div2 && !pd) d_r.push_back(t);
      if (lo && !pl) l_r.push_back(t);
      pc = cclk; pd = div2; pl = lo;
    end
    check("cclk_first", (c_r.size() > 0) ? c_r[0] : 0, 5);
    check("cclk_period", (c_r.size() > 1) ? c_r[1] - c_r[0] : 0, 8);
    check("div2_first", (d_r.size() > 0) ? d_r[0] : 0, 5);
    check("div2_period", (d_r.size() > 1) ? d_r[1] - d_r[0] : 0, 16);
    check("lo_period", (l_r.size() > 1) ? l_r[1] - l_r[0] : 0, 32);

    // asynchronous reset in the middle of RUN
    wait_cclk_high("rst_mid_pre");
    rst = 1'b1;
    #1;
    check("rst_mid_cclk", cclk, 0);
    check("rst_mid_div2", div2, 0);
    check("rst_mid_lo", lo, 0);
    en = 1'b0;
    tick; tick;
    rst = 1'b0;
    nc = 0; pc = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick;
      if (cclk && !pc) nc++;
      pc = cclk;
    end
    check("rst_mid_no_edges", nc, 0);

    // LO disabled
    cfg_lo_en = 1'b0;
    en = 1'b1;
    nc = 0; nl = 0; pc = 1'b0; pl = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      tick;
      if (cclk && !pc) nc++;
      if (lo && !pl) nl++;
      pc = cclk; pl = lo;
    end
    check("lo_off_cclk_rises", nc, 10);
    check("lo_off_lo_rises", nl, 0);
    cfg_lo_en = 1'b1;

    // full window of highs, fb1 latency on the first pulse
    restart(16'd9);
    high_buf = 1'b1;
    phi = 1'b1;
    tick; tick;
    check("fb1_lat_early", fb1, 0);
    tick;
    check("fb1_lat", fb1, 1);
    phi = 1'b0;
    tick; tick;
    pulses(8, 1'b1);
    check("win10_valid_early", out_valid, 0);
    pulse(1'b1, 1'b0);
    check("win10_count", out_count, 10);
    check("win10_valid", out_valid, 1);
    accept;
    check("hs_valid_clr", out_valid, 0);
    check("hs_count_hold", out_count, 10);

    // window end coincident with an accept
    restart(16'd1);
    pulses(2, 1'b1);
    check("same_a_count", out_count, 2);
    check("same_a_valid", out_valid, 1);
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b1);
    check("same_b_count", out_count, 1);
    check("same_b_valid", out_valid, 1);
    check("same_b_overrun", out_overrun, 0);
    accept;
    check("same_b_clr", out_valid, 0);

    // abort mid-window, then a clean window from zero
    restart(16'd9);
    pulses(5, 1'b1);
    wait_cclk_high("abort_pre");
    check("abort_fb1_pre", fb1, 1);
    en = 1'b0;
    tick;
    check("abort_cclk", cclk, 0);
    check("abort_div2", div2, 0);
    check("abort_lo", lo, 0);
    check("abort_fb1", fb1, 0);
    tick; tick; tick;
    check("abort_no_valid", out_valid, 0);
    en = 1'b1;
    tick; tick;
    pulses(7, 1'b1);
    pulses(3, 1'b0);
    check("rearm_count", out_count, 7);
    check("rearm_valid", out_valid, 1);
    accept;

    // 20 highs into a 4-bit counter
    restart(16'd19);
    pulses(20, 1'b1);
    check("sat_valid", out_valid, 1);
`ifdef COCHLEA_CNT_SAT_EN
    check("sat_count", out_count, 15);
    check("sat_flag", out_sat, 1);
`else
    check("wrap_count", out_count, 4);
    check("wrap_flag", out_sat, 0);
`endif
    accept;

    // overrun: two windows with the host stalled
    restart(16'd9);
    pulses(6, 1'b1);
    pulses(4, 1'b0);
    check("ovr_a_count", out_count, 6);
    check("ovr_a_overrun", out_overrun, 0);
    pulses(4, 1'b1);
    pulses(6, 1'b0);
    check("ovr_b_count", out_count, 4);
    check("ovr_b_valid", out_valid, 1);
    check("ovr_b_overrun", out_overrun, 1);
    accept;
    check("ovr_clr_valid", out_valid, 0);
    check("ovr_sticky", out_overrun, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
